// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths, stage-register type and read-port forwarding mux
package wb_regfile_pkg;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int REG_NUM = 2 ** ADDR_W;
    localparam int CNT_W   = 32;

    localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic [ADDR_W-1:0] NOP_REG_ADDR = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
    } wb_stage_t;

    localparam wb_stage_t BUBBLE = '0;

    // Youngest producer wins: EX (unless being flushed), then the stage register, then the array.
    function automatic logic [DATA_W-1:0] read_mux(
        input logic              rst,
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input wb_stage_t         ex,
        input logic              ex_ok,
        input wb_stage_t         wb,
        input logic [DATA_W-1:0] arr
    );
        return (rst || !re || raddr == NOP_REG_ADDR) ? ZERO_WORD :
               (ex_ok && ex.wreg && ex.wd == raddr)  ? ex.wdata  :
               (wb.wreg && wb.wd == raddr)           ? wb.wdata  : arr;
    endfunction
endpackage

// File: rtl/wb_regfile_gpr_array.sv
// wb_regfile_gpr_array: REG_NUM x DATA_W GPR storage, one sync write port, two async raw reads
//   clk, rst          clock, sync active-high reset clearing every register
//   we, waddr, wdata  write port; writes to $0 are dropped
//   raddr1/rdata1     read port 1 (raw, no forwarding)
//   raddr2/rdata2     read port 2 (raw, no forwarding)
module wb_regfile_gpr_array
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);
    logic [REG_NUM-1:0][DATA_W-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && waddr != NOP_REG_ADDR) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        regs_q <= rst ? '0 : regs_d;
    end

    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB stage register, GPR commit, commit counter and forwarding read ports
//   clk, rst                     clock, sync active-high reset
//   stall_i, flush_i             hold stage (no commit) / replace incoming result with bubble
//   wd_i, wreg_i, wdata_i        EX result
//   re1_i, raddr1_i, rdata1_o    read port 1 (combinational, forwarded)
//   re2_i, raddr2_i, rdata2_o    read port 2 (combinational, forwarded)
//   wb_wd_o, wb_wreg_o, wb_wdata_o  stage register contents
//   commit_cnt_o                 number of GPR writes performed
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [CNT_W-1:0]  commit_cnt_o
);
    wb_stage_t         stage_q, stage_d, ex;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              commit;
    logic [DATA_W-1:0] arr1, arr2;

    assign ex = '{wd: wd_i, wreg: wreg_i, wdata: wdata_i};

    // A flush still retires the older instruction sitting in the stage register.
    always_comb begin
        commit  = stage_q.wreg && stage_q.wd != NOP_REG_ADDR && (!stall_i || flush_i);
        stage_d = flush_i ? BUBBLE : stall_i ? stage_q : ex;
        cnt_d   = commit ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= BUBBLE;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    wb_regfile_gpr_array u_gpr (
        .clk    (clk),
        .rst    (rst),
        .we     (commit),
        .waddr  (stage_q.wd),
        .wdata  (stage_q.wdata),
        .raddr1 (raddr1_i),
        .rdata1 (arr1),
        .raddr2 (raddr2_i),
        .rdata2 (arr2)
    );

    assign rdata1_o     = read_mux(rst, re1_i, raddr1_i, ex, !flush_i, stage_q, arr1);
    assign rdata2_o     = read_mux(rst, re2_i, raddr2_i, ex, !flush_i, stage_q, arr2);
    assign wb_wd_o      = stage_q.wd;
    assign wb_wreg_o    = stage_q.wreg;
    assign wb_wdata_o   = stage_q.wdata;
    assign commit_cnt_o = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against a behavioural model
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, wreg_i, re1_i, re2_i;
    logic [4:0]  wd_i, raddr1_i, raddr2_i, wb_wd_o;
    logic [31:0] wdata_i, rdata1_o, rdata2_o, wb_wdata_o, commit_cnt_o;
    logic        wb_wreg_o;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_gpr [32];
    logic [4:0]  m_wd;
    logic        m_wreg;
    logic [31:0] m_wdata;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
        .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
        .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
        .commit_cnt_o(commit_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (rst || !re || a == 0) return 0;
        if (wreg_i && !flush_i && wd_i == a) return wdata_i;
        if (m_wreg && m_wd == a) return m_wdata;
        return m_gpr[a];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".wd"},    {27'b0, wb_wd_o},   {27'b0, m_wd});
        chk({tag, ".wreg"},  {31'b0, wb_wreg_o}, {31'b0, m_wreg});
        chk({tag, ".wdata"}, wb_wdata_o,          m_wdata);
        chk({tag, ".cnt"},   commit_cnt_o,        m_cnt);
        chk({tag, ".rd1"},   rdata1_o,            exp_rd(re1_i, raddr1_i));
        chk({tag, ".rd2"},   rdata2_o,            exp_rd(re2_i, raddr2_i));
    endtask

    task automatic tick();
        logic c;
        c = m_wreg && m_wd != 0 && (!stall_i || flush_i);
        @(posedge clk);
        if (rst) begin
            foreach (m_gpr[i]) m_gpr[i] = 0;
            {m_wd, m_wreg, m_wdata} = '0;
            m_cnt = 0;
        end else begin
            if (c) begin
                m_gpr[m_wd] = m_wdata;
                m_cnt++;
            end
            if (flush_i) {m_wd, m_wreg, m_wdata} = '0;
            else if (!stall_i) {m_wd, m_wreg, m_wdata} = {wd_i, wreg_i, wdata_i};
        end
        #1;
    endtask

    task automatic ex(input logic [4:0] d, input logic w, input logic [31:0] v);
        wd_i = d; wreg_i = w; wdata_i = v;
    endtask

    initial begin
        foreach (m_gpr[i]) m_gpr[i] = 'x;
        {m_wd, m_wreg, m_wdata, m_cnt} = 'x;
        rst = 1; stall_i = 0; flush_i = 0;
        ex(5'd3, 1, 32'hCAFE);
        re1_i = 1; raddr1_i = 3; re2_i = 1; raddr2_i = 17;
        #1;
        chk("rst_force_rd1", rdata1_o, 0);
        chk("rst_force_rd2", rdata2_o, 0);
        tick(); tick();
        check_all("reset");
        chk("reset_cnt", commit_cnt_o, 0);

        rst = 0;
        ex(5'd5, 1, 32'hDEADBEEF); raddr1_i = 5; raddr2_i = 5;
        #1;
        chk("b2b_ex_bypass", rdata1_o, 32'hDEADBEEF);
        check_all("b2b_c0");
        tick();
        ex(5'd0, 0, 0);
        #1;
        chk("b2b_stage", rdata1_o, 32'hDEADBEEF);
        check_all("b2b_c1");
        tick();
        chk("b2b_array", rdata1_o, 32'hDEADBEEF);
        chk("b2b_same_addr", rdata2_o, 32'hDEADBEEF);
        chk("b2b_cnt", commit_cnt_o, 1);
        check_all("b2b_c2");

        ex(5'd0, 1, 32'h1234); raddr1_i = 0; raddr2_i = 0;
        #1;
        chk("zero_ex", rdata1_o, 0);
        tick();
        chk("zero_stage", rdata1_o, 0);
        ex(5'd0, 0, 0);
        tick();
        chk("zero_array", rdata2_o, 0);
        chk("zero_cnt", commit_cnt_o, 1);
        check_all("zero");

        ex(5'd7, 1, 32'hA5); raddr1_i = 7; raddr2_i = 8;
        tick();
        stall_i = 1; ex(5'd8, 1, 32'h5A);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_all("stall_in");
            tick();
            chk("stall_wd", {27'b0, wb_wd_o}, 7);
            chk("stall_cnt", commit_cnt_o, 1);
        end
        stall_i = 0;
        tick();
        ex(5'd0, 0, 0);
        #1;
        chk("stall_rel_gpr7", rdata1_o, 32'hA5);
        chk("stall_rel_wdata", wb_wdata_o, 32'h5A);
        chk("stall_rel_cnt", commit_cnt_o, 2);
        check_all("stall_rel");

        ex(5'd3, 1, 32'h11);
        tick();
        ex(5'd4, 1, 32'h22); flush_i = 1; stall_i = 1; raddr1_i = 4; raddr2_i = 3;
        #1;
        chk("flush_rd4_array", rdata1_o, 0);
        check_all("flush_in");
        tick();
        flush_i = 0; stall_i = 0; ex(5'd0, 0, 0);
        #1;
        chk("flush_gpr3", rdata2_o, 32'h11);
        chk("flush_gpr4", rdata1_o, 0);
        chk("flush_bubble", {31'b0, wb_wreg_o}, 0);
        chk("flush_cnt", commit_cnt_o, 4);
        check_all("flush_out");

        ex(5'd9, 1, 1); tick();
        ex(5'd9, 1, 2); tick();
        ex(5'd9, 1, 3); raddr1_i = 9; raddr2_i = 9; re2_i = 0;
        #1;
        chk("prio_ex", rdata1_o, 3);
        chk("prio_re0", rdata2_o, 0);
        wreg_i = 0;
        #1;
        chk("prio_stage", rdata1_o, 2);
        check_all("prio");

        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 59) == 0);
            stall_i  = ($urandom_range(0, 4) == 0);
            flush_i  = ($urandom_range(0, 6) == 0);
            ex(5'($urandom_range(0, 7)), 1'($urandom), $urandom);
            re1_i    = ($urandom_range(0, 3) != 0);
            re2_i    = ($urandom_range(0, 3) != 0);
            raddr1_i = 5'($urandom_range(0, 9));
            raddr2_i = 5'($urandom_range(0, 9));
            #1;
            check_all("rand");
            tick();
        end
        rst = 0; stall_i = 0; flush_i = 0; ex(5'd0, 0, 0);
        #1;
        check_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
